// File: rtl/calculator_pkg.sv
// Shared types and sizing constants for the calculator datapath.
package calculator_pkg;

  localparam int DATA_W        = 32;
  localparam int MEM_WORD_SIZE = 64;
  localparam int ADDR_W        = 9;

  // Top-level controller sequencing.
  typedef enum logic [1:0] {
    C_IDLE,
    C_LOAD,
    C_ADD,
    C_STORE
  } ctrl_state_t;

  // Result buffer: pack two results, write one SRAM line, repeat.
  typedef enum logic [2:0] {
    B_IDLE,
    B_LOW,
    B_HIGH,
    B_WRITE,
    B_DONE
  } buf_state_t;

endpackage

// File: rtl/result_buffer.sv
// Packs pairs of adder results into SRAM words and writes them to a
// contiguous (wrapping) address range, with early close via flush_i.
//
// Handshake: a result moves when result_valid_i && result_ready_o on a rising
// edge. result_ready_o is a pure function of state (high only in B_LOW and
// B_HIGH), so it never depends on result_valid_i; the producer may hold
// result_valid_i and result_i stable until accepted.
module result_buffer
  import calculator_pkg::*;
#(
  parameter int DATA_W        = calculator_pkg::DATA_W,
  parameter int MEM_WORD_SIZE = calculator_pkg::MEM_WORD_SIZE,
  parameter int ADDR_W        = calculator_pkg::ADDR_W
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [ADDR_W-1:0]        base_addr_i,
  input  logic [ADDR_W-1:0]        end_addr_i,
  input  logic                     result_valid_i,
  input  logic [DATA_W-1:0]        result_i,
  output logic                     result_ready_o,
  input  logic                     flush_i,
  output logic                     wr_en_o,
  output logic [ADDR_W-1:0]        wr_addr_o,
  output logic [MEM_WORD_SIZE-1:0] wr_data_o,
  output logic                     busy_o,
  output logic                     done_o,
  output buf_state_t               state_o
);

  // Packing assumes exactly two results per memory word.
  if (MEM_WORD_SIZE != 2 * DATA_W) begin : g_width_check
    $error("result_buffer: MEM_WORD_SIZE must equal 2*DATA_W");
  end

  buf_state_t        state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] end_q;
  logic [DATA_W-1:0] low_q;
  logic [DATA_W-1:0] high_q;
  logic [DATA_W-1:0] low_d;
  logic [DATA_W-1:0] high_d;
  logic              flush_pending_q;
  logic              xfer;

  assign result_ready_o = (state_q == B_LOW) || (state_q == B_HIGH);
  assign busy_o         = (state_q != B_IDLE);
  assign xfer           = result_valid_i && result_ready_o;
  assign state_o        = state_q;

  // Next values of the two half registers; a flush zero-fills the high half.
  always_comb begin
    low_d  = low_q;
    high_d = high_q;
    if (state_q == B_LOW && xfer) begin
      low_d = result_i;
      if (flush_i) high_d = '0;
    end
    if (state_q == B_HIGH) begin
      if (xfer)         high_d = result_i;
      else if (flush_i) high_d = '0;
    end
  end

  // Buffer FSM with registered write port and done pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= B_IDLE;
      addr_q          <= '0;
      end_q           <= '0;
      low_q           <= '0;
      high_q          <= '0;
      flush_pending_q <= 1'b0;
      wr_en_o         <= 1'b0;
      wr_addr_o       <= '0;
      wr_data_o       <= '0;
      done_o          <= 1'b0;
    end else begin
      wr_en_o <= 1'b0;
      done_o  <= 1'b0;
      low_q   <= low_d;
      high_q  <= high_d;
      case (state_q)
        B_IDLE: begin
          if (start_i) begin
            state_q         <= B_LOW;
            addr_q          <= base_addr_i;
            end_q           <= end_addr_i;
            flush_pending_q <= 1'b0;
          end
        end
        B_LOW: begin
          if (xfer && flush_i) begin
            // Accept the result, then write it as a partial word.
            flush_pending_q <= 1'b1;
            state_q         <= B_WRITE;
            wr_en_o         <= 1'b1;
            wr_addr_o       <= addr_q;
            wr_data_o       <= MEM_WORD_SIZE'({high_d, low_d});
          end else if (xfer) begin
            state_q <= B_HIGH;
          end else if (flush_i) begin
            state_q <= B_DONE;
            done_o  <= 1'b1;
          end
        end
        B_HIGH: begin
          if (xfer || flush_i) begin
            if (flush_i) flush_pending_q <= 1'b1;
            state_q   <= B_WRITE;
            wr_en_o   <= 1'b1;
            wr_addr_o <= addr_q;
            wr_data_o <= MEM_WORD_SIZE'({high_d, low_d});
          end
        end
        B_WRITE: begin
          if (addr_q == end_q || flush_pending_q) begin
            state_q <= B_DONE;
            done_o  <= 1'b1;
          end else begin
            addr_q  <= addr_q + ADDR_W'(1);
            state_q <= B_LOW;
          end
        end
        B_DONE: begin
          state_q <= B_IDLE;
        end
        default: begin
          state_q <= B_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_result_buffer.sv
// Randomized and directed bench for result_buffer with a queue-based model.
module tb_result_buffer;

  localparam int DW = 32;
  localparam int MW = 64;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_a;
  logic [AW-1:0] end_a;
  logic          valid;
  logic [DW-1:0] data;
  logic          ready;
  logic          flush;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [MW-1:0] wr_data;
  logic          busy;
  logic          done;
  calculator_pkg::buf_state_t state;

  // Clock
  always #5 clk = ~clk;

  result_buffer #(.DATA_W(DW), .MEM_WORD_SIZE(MW), .ADDR_W(AW)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .base_addr_i(base_a), .end_addr_i(end_a),
    .result_valid_i(valid), .result_i(data), .result_ready_o(ready),
    .flush_i(flush),
    .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
    .busy_o(busy), .done_o(done), .state_o(state)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: expected writes as {addr, data}
  logic [AW+MW-1:0] exp_q[$];
  int               done_cnt = 0;
  logic [DW-1:0]    res[64];

  // Monitor: compare every write against the model, count done pulses
  always @(negedge clk) begin : mon
    logic [AW+MW-1:0] e;
    if (!rst) begin
      if (wr_en) begin
        check("ready_in_write", ready, 1'b0);
        check("write_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("wr_addr", wr_addr, e[AW+MW-1:MW]);
          check("wr_data", wr_data, e[MW-1:0]);
        end
      end
      if (done) begin
        done_cnt++;
        check("ready_in_done", ready, 1'b0);
        check("busy_in_done", busy, 1'b1);
      end
    end
  end

  // Model: k accepted results form ceil(k/2) words at consecutive addresses,
  // an odd trailing result gets a zero high half.
  task automatic build_exp(input logic [AW-1:0] b, input int k);
    logic [AW-1:0] a;
    logic [DW-1:0] hi;
    for (int i = 0; 2 * i < k; i++) begin
      a  = b + AW'(i);
      hi = (2 * i + 1 < k) ? res[2*i+1] : '0;
      exp_q.push_back({a, hi, res[2*i]});
    end
  endtask

  task automatic start_run(input logic [AW-1:0] b, input logic [AW-1:0] e);
    base_a   = b;
    end_a    = e;
    start    = 1'b1;
    done_cnt = 0;
    @(negedge clk);
    start  = 1'b0;
    base_a = AW'($urandom);
    end_a  = AW'($urandom);
    check("busy_run", busy, 1'b1);
    check("ready_low_state", ready, 1'b1);
  endtask

  // Driver: offers results with random or alternating gaps, holding valid
  // while not accepted; optionally flushes after (or together with) the
  // fl_at-th accepted result.
  task automatic feed(input int nres, input int fl_at, input bit fl_sim, input bit alt);
    int sent = 0;
    int lim;
    int it = 0;
    bit flushed = 0;
    bit hold = 0;
    lim = (fl_at >= 0) ? fl_at : nres;
    while (it < 2000) begin
      flush = 1'b0;
      if (sent < lim) begin
        if (!hold) valid = alt ? (it % 2 == 0) : ($urandom_range(0, 3) != 0);
        data = res[sent];
        if (valid && ready) begin
          sent++;
          hold = 0;
          if (fl_sim && sent == fl_at) begin
            flush   = 1'b1;
            flushed = 1;
          end
        end else begin
          hold = valid;
        end
      end else if (fl_at >= 0 && !flushed) begin
        valid = 1'b0;
        if (ready) begin
          flush   = 1'b1;
          flushed = 1;
        end
      end else begin
        break;
      end
      it++;
      @(negedge clk);
    end
    valid = 1'b0;
    flush = 1'b0;
    check("feed_finished", it < 2000, 1'b1);
  endtask

  task automatic finish_run();
    int n = 0;
    while (done_cnt == 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check("done_count", done_cnt, 1);
    check("exp_empty", exp_q.size(), 0);
    check("busy_after", busy, 1'b0);
    exp_q.delete();
  endtask

  task automatic run(input logic [AW-1:0] b, input logic [AW-1:0] e, input int nres,
                     input int fl_at, input bit fl_sim, input bit alt);
    build_exp(b, (fl_at >= 0) ? fl_at : nres);
    start_run(b, e);
    feed(nres, fl_at, fl_sim, alt);
    finish_run();
  endtask

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  // Main sequence
  initial begin
    logic [AW-1:0] b;
    int d;
    int k;
    rst = 1'b1; start = 1'b0; base_a = '0; end_a = '0;
    valid = 1'b0; data = '0; flush = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_wr_en", wr_en, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", ready, 1'b0);
    check("rst_wr_addr", wr_addr, '0);
    check("rst_wr_data", wr_data, '0);
    check("rst_state", state, calculator_pkg::B_IDLE);
    rst = 1'b0;
    @(negedge clk);

    // Flush while idle is ignored
    done_cnt = 0;
    flush = 1'b1;
    repeat (3) @(negedge clk);
    flush = 1'b0;
    @(negedge clk);
    check("idle_flush_busy", busy, 1'b0);
    check("idle_flush_done", done_cnt, 0);

    // Two full words
    res[0] = 32'h1; res[1] = 32'h2; res[2] = 32'h3; res[3] = 32'h4;
    run(9'h010, 9'h011, 4, -1, 0, 0);
    // Flush in B_LOW after one full word
    res[0] = 32'hA; res[1] = 32'hB;
    run(9'h020, 9'h02F, 0, 2, 0, 0);
    // Flush in B_HIGH: zero high half
    res[0] = 32'hDEADBEEF;
    run(9'h030, 9'h03F, 0, 1, 0, 0);
    // Address wrap 0x1FF -> 0x000
    for (int i = 0; i < 4; i++) res[i] = $urandom;
    run(9'h1FF, 9'h000, 4, -1, 0, 0);
    // Valid with gaps every other cycle
    for (int i = 0; i < 6; i++) res[i] = $urandom;
    run(9'h100, 9'h102, 6, -1, 0, 1);
    // base == end: exactly one write
    for (int i = 0; i < 2; i++) res[i] = $urandom;
    run(9'h055, 9'h055, 2, -1, 0, 0);
    // Flush together with a transfer in B_LOW, then in B_HIGH
    for (int i = 0; i < 4; i++) res[i] = $urandom;
    run(9'h060, 9'h06F, 0, 3, 1, 0);
    for (int i = 0; i < 4; i++) res[i] = $urandom;
    run(9'h070, 9'h07F, 0, 2, 1, 0);
    // Flush before any result: no write
    run(9'h080, 9'h08F, 0, 0, 0, 0);

    // Reset mid-run in B_HIGH, colliding with start/flush/transfer
    start_run(9'h040, 9'h04F);
    valid = 1'b1; data = 32'h1234;
    @(negedge clk);
    valid = 1'b0;
    check("in_high_ready", ready, 1'b1);
    check("in_high_state", state, calculator_pkg::B_HIGH);
    rst = 1'b1; start = 1'b1; valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0; valid = 1'b0; flush = 1'b0;
    check("abort_wr_en", wr_en, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_ready", ready, 1'b0);
    check("abort_wr_addr", wr_addr, '0);
    check("abort_wr_data", wr_data, '0);
    repeat (4) @(negedge clk);
    check("abort_no_done", done_cnt, 0);
    for (int i = 0; i < 4; i++) res[i] = $urandom;
    run(9'h040, 9'h041, 4, -1, 0, 0);

    // Random runs
    for (int r = 0; r < 30; r++) begin
      b = AW'($urandom_range(0, 511));
      d = $urandom_range(0, 3);
      for (int i = 0; i < 2 * (d + 1); i++) res[i] = $urandom;
      if ($urandom_range(0, 2) == 0) begin
        run(b, b + AW'(d), 2 * (d + 1), -1, 0, bit'($urandom_range(0, 1)));
      end else begin
        k = $urandom_range(0, 2 * (d + 1) - 1);
        run(b, b + AW'(d), 0, k, (k >= 1) ? bit'($urandom_range(0, 1)) : 1'b0,
            bit'($urandom_range(0, 1)));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
